// File: rtl/lane_hit_judge.sv
// rtl/lane_hit_judge.sv - one-lane rhythm judge: grades key presses against the lane's bottom rows
// and keeps that lane's combo and score.
module lane_hit_judge #(
  parameter int DEPTH      = 8,
  parameter int HIT_WINDOW = 2,
  parameter int COMBO_W    = 8,
  parameter int SCORE_W    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  softReset,
  input  logic [DEPTH-1:0]      lane,
  input  logic                  shift,
  input  logic                  key,
  output logic                  hit,
  output logic                  perfect,
  output logic                  miss,
  output logic [HIT_WINDOW-1:0] clearNote,
  output logic [COMBO_W-1:0]    combo,
  output logic [SCORE_W-1:0]    score
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t                state, state_n;
  logic                  k1, k2, kd, clr0_d;
  logic                  press, found, hit_n, miss_n, scroll_miss;
  logic [HIT_WINDOW-1:0] window, pick;
  logic [SCORE_W:0]      score_sum;
  logic [SCORE_W-1:0]    score_n;
  logic                  unused_lane;

  assign unused_lane = ^(lane >> HIT_WINDOW);

  assign press = k2 & ~kd & (state == IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (press) state_n = HELD;
      HELD: if (!k2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Row 0 is hidden for one cycle after we cleared it, until the light chain catches up.
  always_comb begin
    window    = lane[HIT_WINDOW-1:0];
    window[0] = lane[0] & ~clr0_d;
    pick      = '0;
    found     = 1'b0;
    for (int i = 0; i < HIT_WINDOW; i++) begin
      if (!found && window[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign hit_n       = press & found;
  assign scroll_miss = shift & lane[0] & ~clr0_d & ~(hit_n & pick[0]);
  assign miss_n      = (press & ~found) | scroll_miss;

  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W+1)'(pick[0] ? 2 : 1);
    score_n   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k1 <= 1'b0; k2 <= 1'b0; kd <= 1'b0; clr0_d <= 1'b0;
      state <= IDLE;
      hit <= 1'b0; perfect <= 1'b0; miss <= 1'b0; clearNote <= '0;
      combo <= '0; score <= '0;
    end else if (softReset) begin
      k1 <= 1'b0; k2 <= 1'b0; kd <= 1'b0; clr0_d <= 1'b0;
      state <= IDLE;
      hit <= 1'b0; perfect <= 1'b0; miss <= 1'b0; clearNote <= '0;
      combo <= '0; score <= '0;
    end else begin
      k1        <= key;
      k2        <= k1;
      kd        <= k2;
      state     <= state_n;
      clr0_d    <= clearNote[0];
      hit       <= hit_n;
      perfect   <= hit_n & pick[0];
      miss      <= miss_n;
      clearNote <= hit_n ? pick : '0;
      if (miss_n) combo <= '0;
      else if (hit_n && combo != {COMBO_W{1'b1}}) combo <= combo + 1'b1;
      if (hit_n) score <= score_n;
    end
  end

endmodule

// File: tb/tb_lane_hit_judge.sv
// tb/tb_lane_hit_judge.sv - directed and randomized checks of lane_hit_judge against a
// behavioural lane model.
module tb_lane_hit_judge;
  localparam int DEPTH = 8, HW = 2, CW = 8, SW = 12;
  localparam int CMAX = (1 << CW) - 1, SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset, softReset, shift, key;
  logic [DEPTH-1:0] lane;
  logic hit, perfect, miss;
  logic [HW-1:0] clearNote;
  logic [CW-1:0] combo;
  logic [SW-1:0] score;

  int checks = 0, errors = 0, printed = 0;

  lane_hit_judge #(.DEPTH(DEPTH), .HIT_WINDOW(HW), .COMBO_W(CW), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .softReset(softReset), .lane(lane), .shift(shift), .key(key),
    .hit(hit), .perfect(perfect), .miss(miss), .clearNote(clearNote), .combo(combo), .score(score)
  );

  always #5 clk = ~clk;

  // Model: key samples history, row-0 cleared last cycle, saturating integer counters.
  bit        m_hit, m_perf, m_miss, m_prev_clr0;
  bit [HW-1:0] m_clear;
  bit [2:0]  hist;
  int        m_combo, m_score;

  always @(posedge clk or posedge reset) begin
    if (reset || softReset) begin
      m_hit = 0; m_perf = 0; m_miss = 0; m_clear = '0; m_prev_clr0 = 0;
      hist = '0; m_combo = 0; m_score = 0;
    end else begin
      bit pr, h, ms;
      int idx;
      pr  = hist[1] && !hist[2];
      idx = -1;
      for (int r = 0; r < HW; r++)
        if (idx < 0 && lane[r] && !(r == 0 && m_prev_clr0)) idx = r;
      h  = pr && idx >= 0;
      ms = (pr && idx < 0) || (shift && lane[0] && !m_prev_clr0 && !(h && idx == 0));
      m_prev_clr0 = m_clear[0];
      m_hit   = h;
      m_perf  = h && idx == 0;
      m_miss  = ms;
      m_clear = h ? HW'(1 << idx) : '0;
      if (ms) m_combo = 0;
      else if (h) m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
      if (h) m_score = (m_score + (idx == 0 ? 2 : 1) > SMAX) ? SMAX : m_score + (idx == 0 ? 2 : 1);
      hist = {hist[1:0], key};
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ({hit, perfect, miss, clearNote} !== {m_hit, m_perf, m_miss, m_clear} ||
          combo !== CW'(m_combo) || score !== SW'(m_score)) begin
        errors++;
        if (printed < 20)
          $display("FAIL cycle_cmp t=%0t actual hit=%b perf=%b miss=%b clr=%b combo=%0d score=%0d required hit=%b perf=%b miss=%b clr=%b combo=%0d score=%0d",
                   $time, hit, perfect, miss, clearNote, combo, score,
                   m_hit, m_perf, m_miss, m_clear, m_combo, m_score);
        printed++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [DEPTH-1:0] l);
    lane = l; key = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_key();
    key = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic soft_clear();
    softReset = 1'b1;
    @(negedge clk);
    softReset = 1'b0;
  endtask

  task automatic pulse_press();
    key = 1'b1; repeat (2) @(negedge clk);
    key = 1'b0; repeat (2) @(negedge clk);
  endtask

  int nh;

  initial begin
    reset = 1'b1; softReset = 1'b0; shift = 1'b0; key = 1'b0; lane = '0;
    repeat (2) @(negedge clk);
    check("rst_hit", hit, 0); check("rst_miss", miss, 0); check("rst_clear", clearNote, 0);
    check("rst_combo", combo, 0); check("rst_score", score, 0);
    reset = 1'b0;

    press(8'b0000_0001);
    check("t2_hit", hit, 1); check("t2_perfect", perfect, 1); check("t2_clear", clearNote, 1);
    check("t2_combo", combo, 1); check("t2_score", score, 2);
    release_key();

    press(8'b0000_0010);
    check("t3_hit", hit, 1); check("t3_perfect", perfect, 0); check("t3_clear", clearNote, 2);
    check("t3_score", score, 3);
    lane = 8'b0000_0011; nh = 0;
    repeat (10) begin @(negedge clk); if (hit) nh++; end
    check("t3_hold_hits", nh, 0);
    release_key();
    press(8'b0000_0011);
    check("t3_rehit", hit, 1); check("t3_rehit_combo", combo, 3); check("t3_rehit_score", score, 5);
    release_key();

    press(8'b0000_0000);
    check("t4_miss", miss, 1); check("t4_combo", combo, 0); check("t4_score", score, 5);
    check("t4_clear", clearNote, 0);
    @(negedge clk);
    check("t4_miss_pulse", miss, 0);
    release_key();

    soft_clear();
    check("soft_combo", combo, 0); check("soft_score", score, 0);
    press(8'b0000_0001);
    soft_clear();
    nh = 0;
    repeat (6) begin @(negedge clk); if (hit) nh++; end
    check("held_through_soft", nh, 1);
    release_key();

    soft_clear();
    repeat (4) begin press(8'b0000_0001); release_key(); end
    press(8'b0000_0010); release_key();
    check("t1_pre_combo", combo, 5); check("t1_pre_score", score, 9);
    #2 reset = 1'b1;
    #1;
    check("t1_async_hit", hit, 0); check("t1_async_combo", combo, 0);
    check("t1_async_score", score, 0); check("t1_async_clear", clearNote, 0);
    @(negedge clk); reset = 1'b0;

    press(8'b0000_0001); release_key();
    lane = 8'b0000_0001; shift = 1'b1;
    @(negedge clk); shift = 1'b0;
    check("t5_scroll_miss", miss, 1); check("t5_scroll_combo", combo, 0);
    key = 1'b1;
    repeat (2) @(negedge clk);
    shift = 1'b1;
    @(negedge clk); shift = 1'b0;
    check("t5_sim_hit", hit, 1); check("t5_sim_miss", miss, 0); check("t5_sim_combo", combo, 1);
    release_key();

    soft_clear();
    lane = 8'b0000_0001;
    repeat (255) pulse_press();
    repeat (3) @(negedge clk);
    check("t6_combo255", combo, 255); check("t6_score510", score, 510);
    pulse_press(); repeat (3) @(negedge clk);
    check("t6_combo_sat", combo, 255); check("t6_score512", score, 512);
    repeat (1900) pulse_press();
    repeat (3) @(negedge clk);
    check("t6_score_sat", score, 4095); check("t6_combo_hold", combo, 255);

    for (int c = 0; c < 4000; c++) begin
      lane      = DEPTH'($urandom);
      shift     = ($urandom_range(0, 3) == 0);
      softReset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) key = ~key;
      if (c == 2000) begin
        #2 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
